// File: rtl/ascon_round_sequencer.sv
// ascon_round_sequencer
//   Control side of the ASCON round-counter interface. Sequences one
//   permutation of p^a (NR_A rounds) or p^b (NR_B rounds). It drives an
//   external init-able up-counter and reads that counter back. It emits the
//   round-constant index, the state-register load/enable strobes and a
//   start/done handshake.
//
// Optional build macro: ASCON_SEQ_ABORT_EN
//   When defined, this adds input abort_i. It returns LOAD/ROUND to IDLE
//   without a done_o pulse. When undefined, a started permutation always
//   runs to done_o.
//
// Ports
//   clock_i       in   1      clock, rising edge
//   reset_i       in   1      asynchronous reset, active high
//   start_i       in   1      request one permutation (sampled only in IDLE)
//   mode_i        in   1      0 = p^a, 1 = p^b (latched on accepted start)
//   abort_i       in   1      abort request (ASCON_SEQ_ABORT_EN only)
//   cpt_i         in   CPT_W  current value of the external round counter
//   cpt_en_o      out  1      counter enable
//   cpt_init_o    out  1      counter synchronous clear (qualified by cpt_en_o)
//   perm_load_o   out  1      state register selects external input
//   perm_en_o     out  1      state register captures round output
//   round_o       out  4      round-constant index
//   last_round_o  out  1      high during the final round cycle
//   busy_o        out  1      high in LOAD and ROUND
//   done_o        out  1      one-cycle completion pulse
module ascon_round_sequencer #(
    parameter int CPT_W = 4,
    parameter int NR_A  = 12,
    parameter int NR_B  = 6
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             mode_i,
`ifdef ASCON_SEQ_ABORT_EN
    input  logic             abort_i,
`endif
    input  logic [CPT_W-1:0] cpt_i,
    output logic             cpt_en_o,
    output logic             cpt_init_o,
    output logic             perm_load_o,
    output logic             perm_en_o,
    output logic [3:0]       round_o,
    output logic             last_round_o,
    output logic             busy_o,
    output logic             done_o
);

    // One extra bit so that the last index (up to 2**CPT_W - 1) and the
    // counter value compare without overflow.
    localparam int CW = CPT_W + 1;
    localparam logic [CW-1:0] LAST_A = CW'(NR_A - 1);
    localparam logic [CW-1:0] LAST_B = CW'(NR_B - 1);
    // p^b uses the tail of the p^a constant table.
    localparam logic [3:0]    OFF_B  = 4'(NR_A - NR_B);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          mode_q;
    logic [CW-1:0] cpt_ext;
    logic [CW-1:0] last_idx;
    logic          at_last;
    logic          at_or_past_last;
    logic [3:0]    base;
    logic [3:0]    round_idx;
    logic          abort;

    // Round bookkeeping derived from the latched mode and the counter value.
    always_comb begin
        cpt_ext         = {1'b0, cpt_i};
        last_idx        = mode_q ? LAST_B : LAST_A;
        at_last         = (cpt_ext == last_idx);
        // A counter that overshoots still ends the permutation, so the FSM
        // cannot hang.
        at_or_past_last = (cpt_ext >= last_idx);
        base            = mode_q ? OFF_B : '0;
        round_idx       = base + 4'(cpt_i);
    end

`ifdef ASCON_SEQ_ABORT_EN
    always_comb abort = abort_i;
`else
    always_comb abort = 1'b0;
`endif

    // State register and mode latch.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state  <= IDLE;
            mode_q <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && start_i) begin
                mode_q <= mode_i;
            end
        end
    end

    // Next-state logic. Abort takes priority over the last-round exit.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_i) state_next = LOAD;
            LOAD:    state_next = abort ? IDLE : ROUND;
            ROUND: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (at_or_past_last) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        cpt_en_o     = 1'b0;
        cpt_init_o   = 1'b0;
        perm_load_o  = 1'b0;
        perm_en_o    = 1'b0;
        round_o      = '0;
        last_round_o = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        case (state)
            LOAD: begin
                cpt_en_o    = 1'b1;
                cpt_init_o  = 1'b1;
                perm_load_o = 1'b1;
                perm_en_o   = 1'b1;
                busy_o      = 1'b1;
            end
            ROUND: begin
                cpt_en_o     = 1'b1;
                perm_en_o    = 1'b1;
                busy_o       = 1'b1;
                round_o      = round_idx;
                last_round_o = at_last;
            end
            DONE:    done_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ascon_round_sequencer.sv
module tb_ascon_round_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       mode;
`ifdef ASCON_SEQ_ABORT_EN
    logic       abort = 1'b0;
`endif
    logic [3:0] cpt;
    logic       cpt_en, cpt_init, perm_load, perm_en, last, busy, done;
    logic [3:0] round;
    logic [10:0] outs;

    // Counter model plus an override used to emulate a broken counter.
    logic [3:0] cnt = '0;
    logic       force_on = 1'b0;
    logic [3:0] force_val = '0;

    int n_checks = 0;
    int n_fail = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) if (cpt_en) cnt <= cpt_init ? 4'd0 : cnt + 4'd1;

    assign cpt  = force_on ? force_val : cnt;
    assign outs = {cpt_en, cpt_init, perm_load, perm_en, round, last, busy, done};

    ascon_round_sequencer #(.CPT_W(4), .NR_A(12), .NR_B(6)) dut (
        .clock_i      (clk),
        .reset_i      (rst),
        .start_i      (start),
        .mode_i       (mode),
`ifdef ASCON_SEQ_ABORT_EN
        .abort_i      (abort),
`endif
        .cpt_i        (cpt),
        .cpt_en_o     (cpt_en),
        .cpt_init_o   (cpt_init),
        .perm_load_o  (perm_load),
        .perm_en_o    (perm_en),
        .round_o      (round),
        .last_round_o (last),
        .busy_o       (busy),
        .done_o       (done)
    );

    // Runs one permutation from IDLE. Call it at a negedge. The expected
    // round sequence is queued up front and popped on each perm_en cycle.
    task automatic run_perm(input logic m, input bit toggle);
        int         nr;
        logic [3:0] off;
        logic [3:0] exp_r;
        bit         got_done;
        nr  = m ? 6 : 12;
        off = m ? 4'd6 : 4'd0;
        for (int i = 0; i < nr; i++) exp_q.push_back(off + 4'(i));
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if ({cpt_en, cpt_init, perm_load, perm_en, busy, done} !== 6'b111110) begin
            n_fail++;
            $display("FAIL load_strobes mode=%0b: got %b expected %b", m,
                     {cpt_en, cpt_init, perm_load, perm_en, busy, done}, 6'b111110);
        end
        got_done = 1'b0;
        for (int cyc = 2; cyc <= nr + 4 && !got_done; cyc++) begin
            @(negedge clk);
            if (toggle) mode = ~mode;
            if (perm_en) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_round mode=%0b: got round %0d at cycle %0d expected none", m, round, cyc);
                end else begin
                    exp_r = exp_q.pop_front();
                    if ({perm_load, busy, round, last} !== {1'b0, 1'b1, exp_r, exp_q.size() == 0}) begin
                        n_fail++;
                        $display("FAIL round_seq mode=%0b cycle %0d: got load=%b busy=%b round=%0d last=%b expected load=0 busy=1 round=%0d last=%b",
                                 m, cyc, perm_load, busy, round, last, exp_r, exp_q.size() == 0);
                    end
                end
            end
            if (done) begin
                got_done = 1'b1;
                n_checks++;
                if (cyc != nr + 2 || exp_q.size() != 0 || busy !== 1'b0 || perm_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL done_timing mode=%0b: got cycle %0d busy=%b left=%0d expected cycle %0d busy=0 left=0",
                             m, cyc, busy, exp_q.size(), nr + 2);
                end
            end
        end
        n_checks++;
        if (!got_done) begin
            n_fail++;
            $display("FAIL done_timeout mode=%0b: got no done_o expected done_o at cycle %0d", m, nr + 2);
        end
        exp_q.delete();
        @(negedge clk);
        n_checks++;
        if (outs !== 11'd0) begin
            n_fail++;
            $display("FAIL idle_after_done mode=%0b: got %b expected all zero", m, outs);
        end
    endtask

    task automatic test_reset();
        bit seen;
        rst   = 1'b1;
        start = 1'b1;
        mode  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (outs !== 11'd0) begin
                n_fail++;
                $display("FAIL reset_outputs: got %b expected all zero", outs);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({perm_load, busy, cpt_init} !== 3'b111) begin
            n_fail++;
            $display("FAIL first_load: got load=%b busy=%b init=%b expected 1 1 1", perm_load, busy, cpt_init);
        end
        start = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL first_done: got no done_o expected done_o within 20 cycles");
        end
        @(negedge clk);
    endtask

    task automatic test_pa();
        run_perm(1'b0, 1'b0);
    endtask

    task automatic test_pb();
        run_perm(1'b1, 1'b0);
        run_perm(1'b1, 1'b1);
        run_perm(1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        int  loads[$];
        int  dones;
        bit  idle_before;
        bit  prev_idle;
        bit  seen;
        dones       = 0;
        idle_before = 1'b0;
        prev_idle   = 1'b0;
        mode        = 1'b0;
        start       = 1'b1;
        for (int t = 0; t < 40 && loads.size() < 2; t++) begin
            @(negedge clk);
            if (perm_load) begin
                if (loads.size() == 1) idle_before = prev_idle;
                loads.push_back(t);
            end
            if (done) dones++;
            prev_idle = (busy === 1'b0 && done === 1'b0);
        end
        start = 1'b0;
        n_checks++;
        if (loads.size() != 2 || loads[1] - loads[0] != 15) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d loads spacing %0d expected 2 loads spacing 15",
                     loads.size(), loads.size() == 2 ? loads[1] - loads[0] : -1);
        end
        n_checks++;
        if (dones != 1 || !idle_before) begin
            n_fail++;
            $display("FAIL b2b_handshake: got dones=%0d idle_before=%0b expected dones=1 idle_before=1", dones, idle_before);
        end
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        @(negedge clk);
        n_checks++;
        if (!seen || perm_load !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_no_queue: got done=%0b load=%b expected done=1 load=0", seen, perm_load);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        mode  = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (perm_en && round == 4'd5) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL reach_round5: got no round_o=5 expected round_o=5");
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (outs !== 11'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %b expected all zero before next edge", outs);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_done: got done=%b busy=%b expected 0 0", done, busy);
        end
        run_perm(1'b0, 1'b0);
    endtask

    task automatic test_broken_counter();
        mode  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        force_on  = 1'b1;
        force_val = 4'd15;
        @(negedge clk);
        n_checks++;
        if ({perm_en, round, last} !== {1'b1, 4'd5, 1'b0}) begin
            n_fail++;
            $display("FAIL overshoot_round: got en=%b round=%0d last=%b expected en=1 round=5 last=0", perm_en, round, last);
        end
        @(negedge clk);
        force_on = 1'b0;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL overshoot_done: got done=%b busy=%b expected 1 0", done, busy);
        end
        @(negedge clk);
    endtask

`ifdef ASCON_SEQ_ABORT_EN
    task automatic test_abort();
        bit found;
        int dones;
        mode  = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (perm_en && round == 4'd3) found = 1'b1;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if (!found || {busy, perm_en, cpt_en, done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL abort_mid: got found=%0b busy=%b en=%b cpt_en=%b done=%b expected 1 0 0 0 0",
                     found, busy, perm_en, cpt_en, done);
        end
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        n_checks++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d done pulses expected 0", dones);
        end
        mode  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (last) found = 1'b1;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if (!found || done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_last: got found=%0b done=%b busy=%b expected 1 0 0", found, done, busy);
        end
        run_perm(1'b0, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_pa();
        test_pb();
        test_back_to_back();
        test_reset_mid();
        test_broken_counter();
`ifdef ASCON_SEQ_ABORT_EN
        test_abort();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
